// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exec_pkg
// Brief   : Opcodes, instruction field positions and state encoding for
//           exec_ctrl.
// Rev     : 1.0
// ============================================================================
package exec_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 14;
    localparam int FSEL_MSB = 13;
    localparam int FSEL_LSB = 11;
    localparam int ADDR_MSB = 10;
    localparam int ADDR_LSB = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : exec_ctrl
// Brief   : Expands 16-bit instructions into the one-cycle strobe plus
//           one-cycle gap pattern of exec_unit; READ data returns on a
//           valid/ready response channel.
// Rev     : 1.0
// ============================================================================
module exec_ctrl
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [7:0]  retired,
    output logic        ld,
    output logic        write,
    output logic        en_alu,
    output logic        en_mem,
    output logic [2:0]  addr,
    output logic [7:0]  indata,
    output logic [2:0]  f_select,
    input  logic [7:0]  outdata
);

    state_t     r_state;
    logic [1:0] r_op;
    logic [1:0] w_op;

    assign w_op = instr[OP_MSB:OP_LSB];

    // Strobes are set on the accept edge so they are high exactly for ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            in_ready  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            retired   <= 8'h00;
            ld        <= 1'b0;
            write     <= 1'b0;
            en_alu    <= 1'b0;
            en_mem    <= 1'b0;
            addr      <= 3'd0;
            indata    <= 8'h00;
            f_select  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op     <= w_op;
                        addr     <= instr[ADDR_MSB:ADDR_LSB];
                        f_select <= instr[FSEL_MSB:FSEL_LSB];
                        indata   <= instr[IMM_MSB:IMM_LSB];
                        in_ready <= 1'b0;
                        ld       <= (w_op == OP_LOAD);
                        write    <= (w_op == OP_LOAD);
                        en_mem   <= (w_op == OP_LOAD) || (w_op == OP_READ);
                        en_alu   <= (w_op == OP_ALU);
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ld     <= 1'b0;
                    write  <= 1'b0;
                    en_alu <= 1'b0;
                    en_mem <= 1'b0;
                    if (r_op == OP_NOP) begin
                        retired  <= retired + 8'd1;
                        in_ready <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        if (r_op == OP_READ) begin
                            rsp_data <= outdata;
                        end
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_op == OP_READ) begin
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        retired  <= retired + 8'd1;
                        in_ready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        retired   <= retired + 8'd1;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_exec_ctrl
// Brief   : Directed bench for exec_ctrl with a behavioural exec_unit memory
//           and a scoreboard for READ responses.
// Rev     : 1.0
// ============================================================================
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [7:0]  retired;
    logic        ld, write, en_alu, en_mem;
    logic [2:0]  addr;
    logic [7:0]  indata;
    logic [2:0]  f_select;
    logic [7:0]  outdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    exec_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .retired  (retired),
        .ld       (ld),
        .write    (write),
        .en_alu   (en_alu),
        .en_mem   (en_mem),
        .addr     (addr),
        .indata   (indata),
        .f_select (f_select),
        .outdata  (outdata)
    );

    always #5 clk = ~clk;

    // Behavioural exec_unit: 8x8 memory, ALU operates on mem[0] and mem[1].
    logic [7:0] mem [8];
    logic [7:0] alu_res;
    always_comb begin
        case (f_select)
            3'd0:    alu_res = mem[0] + mem[1];
            3'd1:    alu_res = mem[0] - mem[1];
            3'd2:    alu_res = mem[0] & mem[1];
            3'd3:    alu_res = mem[0] | mem[1];
            default: alu_res = mem[0] ^ mem[1];
        endcase
    end
    always @(posedge clk) begin
        if (ld && write && en_mem) mem[addr] <= indata;
        else if (en_alu)           mem[addr] <= alu_res;
    end
    assign outdata = mem[addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor and strobe-exclusivity check.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("strobe_excl", {31'd0, en_alu && (en_mem || ld || write)}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {24'd0, rsp_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        bit ok = 1'b0;
        @(posedge clk); #1;
        instr    = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic strobes(input string name, input logic [3:0] exp);
        check(name, {28'd0, ld, write, en_mem, en_alu}, {28'd0, exp});
    endtask

    initial begin
        int cyc;
        int acc;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rst_n = 1'b0; in_valid = 1'b0; instr = 16'h0000; rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        strobes("rst_strobes", 4'b0000);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_retired", {24'd0, retired}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Two LOADs: mem[0]=2, mem[1]=3
        send(16'h4002);
        @(negedge clk); strobes("load0_issue", 4'b1110);
        check("load0_addr", {29'd0, addr}, 32'd0);
        check("load0_indata", {24'd0, indata}, 32'h02);
        @(negedge clk); strobes("load0_gap", 4'b0000);
        send(16'h4103);
        @(negedge clk); strobes("load1_issue", 4'b1110);
        check("load1_addr", {29'd0, addr}, 32'd1);
        check("load1_indata", {24'd0, indata}, 32'h03);
        @(negedge clk); strobes("load1_gap", 4'b0000);
        check("load1_gap_addr", {29'd0, addr}, 32'd1);
        @(negedge clk); check("retired_2", {24'd0, retired}, 32'd2);

        // ALU add into mem[2], then read it back with rsp_ready high
        send(16'h8200);
        @(negedge clk); strobes("alu_issue", 4'b0001);
        check("alu_addr", {29'd0, addr}, 32'd2);
        @(negedge clk); strobes("alu_gap", 4'b0000);
        exp_q.push_back(8'h05);
        send(16'hC200);
        @(negedge clk); strobes("read_issue", 4'b0010);
        @(negedge clk); check("read_gap_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); check("read_resp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk); check("read_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("read_done_ready", {31'd0, in_ready}, 32'd1);
        check("retired_4", {24'd0, retired}, 32'd4);

        // READ with backpressure, a LOAD waiting behind it
        @(posedge clk); #1; rsp_ready = 1'b0;
        exp_q.push_back(8'h03);
        send(16'hC100);
        @(negedge clk); strobes("stall_issue", 4'b0010);
        @(negedge clk);
        @(posedge clk); #1; in_valid = 1'b1; instr = 16'h4707;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data", {24'd0, rsp_data}, 32'h03);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            strobes("stall_strobes", 4'b0000);
        end
        check("stall_retired", {24'd0, retired}, 32'd4);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_accept_ready", {31'd0, in_ready}, 32'd1);
        check("post_accept_valid", {31'd0, rsp_valid}, 32'd0);
        check("retired_5", {24'd0, retired}, 32'd5);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); strobes("held_load_issue", 4'b1110);
        check("held_load_addr", {29'd0, addr}, 32'd7);
        check("held_load_indata", {24'd0, indata}, 32'h07);
        @(negedge clk); @(negedge clk);
        check("retired_6", {24'd0, retired}, 32'd6);

        // Reset during the ISSUE cycle of a LOAD to mem[0]
        send(16'h4055);
        #2; rst_n = 1'b0; #1;
        strobes("rst_mid_strobes", 4'b0000);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_retired", {24'd0, retired}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1;

        // 256 back-to-back NOPs
        @(posedge clk); #1; in_valid = 1'b1; instr = 16'h0000;
        cyc = 0; acc = 0;
        while (acc < 256 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (in_ready) begin
                acc++;
                if (acc == 256) check("nop_retired_255", {24'd0, retired}, 32'd255);
            end
        end
        @(posedge clk); #1; in_valid = 1'b0;
        check("nop_cycles", cyc, 32'd511);
        @(negedge clk); @(negedge clk);
        check("nop_wrap", {24'd0, retired}, 32'd0);

        // mem[0] must still hold its pre-reset value
        exp_q.push_back(8'h02);
        send(16'hC000);
        drain();
        exp_q.push_back(8'h05);
        send(16'hC200);
        drain();
        check("final_retired", {24'd0, retired}, 32'd2);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/exec_ctrl.md
# exec_ctrl

Instruction sequencer for `exec_unit` (8×8-bit register memory plus 8-bit ALU). It accepts 16-bit instructions over a valid/ready handshake and expands each into the single-cycle strobe pattern `exec_unit` requires: one active cycle, then one all-low separation cycle. READ results return on a separate valid/ready response channel. It sits between the instruction source (fetch logic or a bench) and `exec_unit`, and is the only driver of `exec_unit` inputs.

## Interface
- No parameters; widths fixed by `exec_unit` (8-bit data, 3-bit addr, 3-bit f_select).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  controller can accept; reset 1
- `instr`  in  16  [15:14] op, [13:11] f_select, [10:8] addr, [7:0] imm
- `rsp_valid`  out  1  READ data available; reset 0
- `rsp_ready`  in  1  consumer takes response
- `rsp_data`  out  8  READ data; reset 0
- `retired`  out  8  count of completed instructions, wraps 255→0; reset 0
- `ld`, `write`, `en_alu`, `en_mem`  out  1 each  `exec_unit` strobes; reset 0
- `addr`  out  3  `exec_unit` address; reset 0
- `indata`  out  8  `exec_unit` write data; reset 0
- `f_select`  out  3  ALU function; reset 0
- `outdata`  in  8  `exec_unit` read data

## Operation
- Opcodes: 00 NOP, 01 LOAD (mem[addr] ← imm), 10 ALU (mem[addr] ← ALU(f_select)), 11 READ (rsp_data ← mem[addr]).
- States: IDLE, ISSUE, GAP, RESP.
- IDLE: `in_ready`=1; on `in_valid`&&`in_ready`, latch `instr` and go to ISSUE. All strobes low.
- ISSUE, one cycle, with `addr`/`f_select`/`indata` driven from the latched fields:
  - LOAD: `ld`=`write`=`en_mem`=1.
  - ALU: `en_alu`=1.
  - READ: `en_mem`=1, `write`=0, `ld`=0.
  - NOP: no strobes; go directly to IDLE and increment `retired`.
  - For all other opcodes, go to GAP.
- GAP, one cycle: all strobes 0; `addr`/`f_select`/`indata` hold their ISSUE values.
  - LOAD/ALU: increment `retired`, then go to IDLE.
  - READ: go to RESP.
- READ capture: `outdata` is registered into `rsp_data` on the clock edge that ends ISSUE.
- RESP: `rsp_valid`=1 and `rsp_data` stable until `rsp_ready`. On the accept edge, `rsp_valid`→0, `retired`++, state → IDLE.
- `in_ready` is 0 in ISSUE, GAP and RESP; instructions are never dropped or overwritten.
- Only one strobe group is active in any cycle. `en_alu` and `en_mem` are never both high.

## Timing
- Accept at edge E0, then ISSUE during cycle E0→E1, then GAP during E1→E2.
- LOAD/ALU: back in IDLE after E2; `retired` increments at E2. Peak rate is 1 instruction per 3 cycles.
- NOP: IDLE after E1; 2 cycles per instruction.
- READ: `rsp_valid` rises after E2. With `rsp_ready` held high, it drops after E3, so minimum occupancy is 4 cycles.
- A `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- Asynchronous reset in any state: outputs return to their reset values immediately, state → IDLE, and any pending response is discarded.
- `retired` wraps 255→0 with no flag.

## Structure
- Package `exec_pkg` holds:
  - opcode localparams `OP_NOP`/`OP_LOAD`/`OP_ALU`/`OP_READ`
  - instruction field bit positions
  - the state encoding.
- A single module `exec_ctrl`; no sub-module. Decode is a few lines inside the ISSUE output logic.
- Top level instantiates `exec_ctrl` and `exec_unit` side by side, with strobes wired 1:1.

## Test plan
- Reset: hold `rst_n`=0 → all strobes 0, `in_ready`=1, `rsp_valid`=0, `retired`=0.
- LOAD 0x4002 (addr 0, imm 0x02), then LOAD 0x4103 (addr 1, imm 0x03):
  - `ld`/`write`/`en_mem` are high exactly one cycle each, with addr 0/1 and indata 0x02/0x03.
  - A 0-strobe gap follows each.
  - `retired`=2.
- ALU 0x8200 (f_select 0, addr 2) → `en_alu` high for one cycle with addr=2; then READ 0xC200 → `rsp_valid` with `rsp_data`=0x05 (2+3).
- READ with `rsp_ready` held low for 5 cycles:
  - `rsp_valid` and `rsp_data` stay stable throughout.
  - `in_ready`=0 throughout, and a waiting `in_valid` is not accepted.
  - After accept, `in_ready`=1 on the next cycle.
- 256 NOPs → `retired` wraps to 0; each NOP takes 2 cycles.
- Assert `rst_n`=0 during the ISSUE cycle of a LOAD → strobes drop immediately and no write completes; after release, a READ of that address returns its pre-reset contents.
